// File: rtl/mips_fetch_pkg.sv
// Shared definitions for the instruction-fetch sequencer.
//   fetch_state_t : sequencer states (HALTED is only reachable when the
//                   FETCH_HALT_EN macro is defined)
//   HALT_WORD     : syscall encoding that stops fetching in halt builds
//   DEF_*         : default widths, reset PC and sequential PC increment
package mips_fetch_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      REQ    = 3'd1,
      DRAIN  = 3'd2,
      VALID  = 3'd3,
      HALTED = 3'd4
   } fetch_state_t;

   localparam logic [31:0] HALT_WORD    = 32'h0000_000C;
   localparam int          DEF_ADDR_W   = 32;
   localparam int          DEF_DATA_W   = 32;
   localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
   localparam int          DEF_PC_STEP  = 4;

endpackage

// File: rtl/fetch_pc_next.sv
// Next-PC selection for the fetch sequencer (purely combinational).
// Ports:
//   pc          in   ADDR_W  current PC register
//   redirectPc  in   ADDR_W  control-flow target; low two bits are dropped
//   selRedirect in   1       take the redirect target (highest priority)
//   selStep     in   1       advance to the sequential successor
//   pcNext      out  ADDR_W  value the PC register loads this cycle
//   pcPlus4     out  ADDR_W  pc + PC_STEP, wrapping modulo 2^ADDR_W
module fetch_pc_next import mips_fetch_pkg::*; #(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int PC_STEP = DEF_PC_STEP
) (
   input  logic [ADDR_W-1:0] pc,
   input  logic [ADDR_W-1:0] redirectPc,
   input  logic              selRedirect,
   input  logic              selStep,
   output logic [ADDR_W-1:0] pcNext,
   output logic [ADDR_W-1:0] pcPlus4
);

   localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(PC_STEP);
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(3));

   // Plain modular add: the top word wraps to zero without any flag.
   assign pcPlus4 = pc + STEP;

   always_comb begin
      pcNext = pc;
      if (selRedirect) begin
         pcNext = redirectPc & ALIGN_MASK;
      end else if (selStep) begin
         pcNext = pcPlus4;
      end
   end

endmodule

// File: rtl/fetch_sequencer.sv
// Multi-cycle instruction-fetch controller. Owns the PC, issues one word
// fetch at a time to a variable-latency memory and presents each returned
// instruction (with its PC and PC+step) to the datapath.
// Build option: define FETCH_HALT_EN to stop fetching after the syscall
// word (HALT_WORD) is accepted; otherwise halted is tied low.
// Ports:
//   clk, rst_n          clock; asynchronous active-low reset
//   imem_req/imem_addr  fetch request and address (held until imem_ack)
//   imem_ack/imem_rdata memory response for the outstanding request
//   if_valid/if_ready   instruction handshake to the datapath
//   if_inst/if_pc/if_pc_plus4  delivered instruction, its PC and PC+step
//   redirect/redirect_pc       control-flow change and its target
//   stall               holds off starting a new fetch
//   halted              fetch stopped by the halt instruction
//   dbgState            current sequencer state (fetch_state_t encoding)
//
// Handshake rules: imem_req, once raised, stays high with imem_addr stable
// until the cycle imem_ack is seen (only reset withdraws it). if_valid,
// once raised, holds if_inst/if_pc/if_pc_plus4 stable until the cycle
// if_valid & if_ready is seen; a redirect in that cycle cancels the
// transfer and the instruction counts as not accepted.
module fetch_sequencer import mips_fetch_pkg::*; #(
   parameter int                ADDR_W   = DEF_ADDR_W,
   parameter int                DATA_W   = DEF_DATA_W,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC),
   parameter int                PC_STEP  = DEF_PC_STEP
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [DATA_W-1:0] imem_rdata,
   output logic              if_valid,
   input  logic              if_ready,
   output logic [DATA_W-1:0] if_inst,
   output logic [ADDR_W-1:0] if_pc,
   output logic [ADDR_W-1:0] if_pc_plus4,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   input  logic              stall,
   output logic              halted,
   output logic [2:0]        dbgState
);

   localparam logic [ADDR_W-1:0] RESET_PC_PLUS = RESET_PC + ADDR_W'(PC_STEP);

   fetch_state_t      state;
   fetch_state_t      stateNext;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] pcNext;
   logic [ADDR_W-1:0] pcPlus4;
   logic [ADDR_W-1:0] addrQ;
   logic [DATA_W-1:0] instQ;
   logic [ADDR_W-1:0] ifPcQ;
   logic [ADDR_W-1:0] ifPcPlus4Q;
   logic              selRedirect;
   logic              selStep;
   logic              capture;

   fetch_pc_next #(
      .ADDR_W  (ADDR_W),
      .PC_STEP (PC_STEP)
   ) uPcNext (
      .pc          (pc),
      .redirectPc  (redirect_pc),
      .selRedirect (selRedirect),
      .selStep     (selStep),
      .pcNext      (pcNext),
      .pcPlus4     (pcPlus4)
   );

   // Next-state / control decode. Redirect is checked first everywhere so
   // it overrides both the memory response and the datapath handshake.
   always_comb begin
      stateNext   = state;
      selRedirect = 1'b0;
      selStep     = 1'b0;
      capture     = 1'b0;
      case (state)
         IDLE: begin
            if (redirect) begin
               selRedirect = 1'b1;
               stateNext   = stall ? IDLE : REQ;
            end else if (!stall) begin
               stateNext = REQ;
            end
         end
         REQ: begin
            if (redirect) begin
               selRedirect = 1'b1;
               // Without an ack the old request is still in flight and must
               // be drained before the new address can be issued.
               stateNext   = imem_ack ? REQ : DRAIN;
            end else if (imem_ack) begin
               capture   = 1'b1;
               stateNext = VALID;
            end
         end
         DRAIN: begin
            // A later redirect simply replaces the pending target.
            if (redirect) begin
               selRedirect = 1'b1;
            end
            if (imem_ack) begin
               stateNext = REQ;
            end
         end
         VALID: begin
            if (redirect) begin
               selRedirect = 1'b1;
               stateNext   = stall ? IDLE : REQ;
            end else if (if_ready) begin
               selStep   = 1'b1;
               stateNext = stall ? IDLE : REQ;
`ifdef FETCH_HALT_EN
               if (instQ == DATA_W'(HALT_WORD)) begin
                  stateNext = HALTED;
               end
`endif
            end
         end
`ifdef FETCH_HALT_EN
         HALTED: begin
            stateNext = HALTED;
         end
`endif
         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         pc         <= RESET_PC;
         addrQ      <= RESET_PC;
         instQ      <= '0;
         ifPcQ      <= RESET_PC;
         ifPcPlus4Q <= RESET_PC_PLUS;
      end else begin
         state <= stateNext;
         pc    <= pcNext;
         // While a request waits for its ack pcNext equals pc, so reloading
         // here never moves the address of an outstanding request.
         if (stateNext == REQ) begin
            addrQ <= pcNext;
         end
         if (capture) begin
            instQ      <= imem_rdata;
            ifPcQ      <= pc;
            ifPcPlus4Q <= pcPlus4;
         end
      end
   end

   assign imem_req    = (state == REQ) || (state == DRAIN);
   assign imem_addr   = addrQ;
   assign if_valid    = (state == VALID);
   assign if_inst     = instQ;
   assign if_pc       = ifPcQ;
   assign if_pc_plus4 = ifPcPlus4Q;
   assign dbgState    = state;

`ifdef FETCH_HALT_EN
   assign halted = (state == HALTED);
`else
   assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: a memory responder with programmable latency,
// an architectural PC model checked every cycle, and directed scenarios
// with literal expectations.
`timescale 1ns/1ps
module tb_fetch_sequencer;
   import mips_fetch_pkg::*;

   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic        if_valid;
   logic        if_ready = 1'b1;
   logic [31:0] if_inst;
   logic [31:0] if_pc;
   logic [31:0] if_pc_plus4;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        stall = 1'b0;
   logic        halted;
   logic [2:0]  dbgState;

   int checks = 0;
   int errors = 0;
   int ackDelay = 0;
   int accepted = 0;
   logic [31:0] startQ[$];

   always #5 clk = ~clk;

   fetch_sequencer #(
      .ADDR_W   (32),
      .DATA_W   (32),
      .RESET_PC (RST_PC),
      .PC_STEP  (4)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .if_valid    (if_valid),
      .if_ready    (if_ready),
      .if_inst     (if_inst),
      .if_pc       (if_pc),
      .if_pc_plus4 (if_pc_plus4),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .stall       (stall),
      .halted      (halted),
      .dbgState    (dbgState)
   );

   // Memory image: address 0x40 holds the syscall word.
   function automatic logic [31:0] memWord(input logic [31:0] a);
      if (a == 32'h0000_0040) return 32'h0000_000C;
      return a ^ 32'hDEAD_0000;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chkB(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- memory responder ----------------
   int   rspAge = 0;
   logic rspWasReq = 1'b0;
   logic rspAcked = 1'b0;
   always @(posedge clk) begin
      #1;
      if (!rst_n) begin
         rspAge = 0; rspWasReq = 1'b0; rspAcked = 1'b0;
         imem_ack = 1'b0; imem_rdata = 32'h0;
      end else begin
         if (imem_req) begin
            if (!rspWasReq || rspAcked) rspAge = 0;
            else rspAge++;
         end
         imem_ack   = imem_req && (rspAge >= ackDelay);
         imem_rdata = imem_ack ? memWord(imem_addr) : 32'h0;
         rspWasReq  = imem_req;
         rspAcked   = imem_ack;
      end
   end

   // ---------------- architectural model + per-cycle compare ----------------
   logic [31:0] mPc = RST_PC;
   logic        mHalted = 1'b0;
   logic        pReq = 1'b0, pAck = 1'b0, pStall = 1'b0;
   logic [31:0] pAddr = RST_PC;
   always @(negedge clk) begin
      if (!rst_n) begin
         mPc = RST_PC; mHalted = 1'b0;
         pReq = 1'b0; pAck = 1'b0; pStall = 1'b0; pAddr = RST_PC;
      end else begin
         chkB("halted", halted, mHalted);
         if (mHalted) begin
            chkB("halt_no_req", imem_req, 1'b0);
            chkB("halt_no_valid", if_valid, 1'b0);
         end
         if (pReq && !pAck) chkB("req_held", imem_req, 1'b1);
         if (imem_req) begin
            if (!pReq || pAck) begin
               if (!pReq) chkB("start_unstalled", pStall, 1'b0);
               chk("fetch_addr", imem_addr, mPc);
               startQ.push_back(imem_addr);
            end else begin
               chk("addr_stable", imem_addr, pAddr);
            end
         end
         if (if_valid) begin
            chk("if_pc", if_pc, mPc);
            chk("if_inst", if_inst, memWord(mPc));
            chk("if_pc_plus4", if_pc_plus4, mPc + 32'd4);
         end
         if (redirect && !mHalted) begin
            mPc = redirect_pc & ~32'h3;
         end else if (if_valid && if_ready) begin
            accepted++;
`ifdef FETCH_HALT_EN
            if (memWord(mPc) == HALT_WORD) mHalted = 1'b1;
`endif
            mPc = mPc + 32'd4;
         end
         pReq = imem_req; pAck = imem_ack; pStall = stall; pAddr = imem_addr;
      end
   end

   // ---------------- driver helpers ----------------
   task automatic drv();
      @(posedge clk); #2;
   endtask

   task automatic waitValid(input logic [31:0] pc, input string nm);
      int n = 0;
      @(negedge clk);
      while (!(if_valid && if_pc == pc) && n < 60) begin
         @(negedge clk); n++;
      end
      chkB(nm, if_valid && (if_pc == pc), 1'b1);
   endtask

   task automatic waitValidAny(input string nm);
      int n = 0;
      @(negedge clk);
      while (!if_valid && n < 60) begin
         @(negedge clk); n++;
      end
      chkB(nm, if_valid, 1'b1);
   endtask

   task automatic waitReq(input string nm);
      int n = 0;
      @(negedge clk);
      while (!imem_req && n < 60) begin
         @(negedge clk); n++;
      end
      chkB(nm, imem_req, 1'b1);
   endtask

   task automatic waitReqNoAck(input string nm);
      int n = 0;
      @(negedge clk);
      while (!(imem_req && !imem_ack) && n < 60) begin
         @(negedge clk); n++;
      end
      chkB(nm, imem_req && !imem_ack, 1'b1);
   endtask

   task automatic waitAck(input string nm);
      int n = 0;
      @(negedge clk);
      while (!imem_ack && n < 60) begin
         @(negedge clk); n++;
      end
      chkB(nm, imem_ack, 1'b1);
   endtask

   task automatic checkResetValues(input string nm);
      chkB({nm, "_req"}, imem_req, 1'b0);
      chk({nm, "_addr"}, imem_addr, RST_PC);
      chkB({nm, "_valid"}, if_valid, 1'b0);
      chk({nm, "_inst"}, if_inst, 32'h0);
      chk({nm, "_pc"}, if_pc, RST_PC);
      chk({nm, "_pc_plus4"}, if_pc_plus4, RST_PC + 32'd4);
      chkB({nm, "_halted"}, halted, 1'b0);
   endtask

   // ---------------- directed scenarios ----------------
   logic [31:0] t1Addr[3] = '{32'h0, 32'h4, 32'h8};
   logic [31:0] t1Pc4[3]  = '{32'h4, 32'h8, 32'hC};

   initial begin
      int n;
      int cnt24;

      repeat (3) @(negedge clk);
      checkResetValues("rst");
      drv(); rst_n = 1'b1;

      // 1: ack every cycle, ready high -> one instruction per two cycles
      @(negedge clk);
      chkB("t1_idle_req", imem_req, 1'b0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (i % 2 == 0) begin
            chkB("t1_req", imem_req, 1'b1);
            chk("t1_addr", imem_addr, t1Addr[i/2]);
         end else begin
            chkB("t1_valid", if_valid, 1'b1);
            chk("t1_if_pc", if_pc, t1Addr[i/2]);
            chk("t1_if_pc_plus4", if_pc_plus4, t1Pc4[i/2]);
         end
      end

      // 2: ack latency 3, ready held low two cycles
      drv(); if_ready = 1'b0; ackDelay = 3;
      waitValid(32'hC, "t2_valid_c");
      @(negedge clk);
      chkB("t2_hold_valid", if_valid, 1'b1);
      chk("t2_hold_inst", if_inst, 32'hDEAD_000C);
      drv(); if_ready = 1'b1;
      @(negedge clk);
      drv(); if_ready = 1'b0;
      n = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (if_valid) break;
         if (imem_req) n++;
      end
      chk("t2_req_cycles", 32'(n), 32'd4);
      chk("t2_pc_0x10", if_pc, 32'h10);
      @(negedge clk);
      chkB("t2_hold_valid2", if_valid, 1'b1);
      drv(); if_ready = 1'b1; ackDelay = 1000;

      // 3: redirect to 0x103 while a request waits for its ack
      waitReqNoAck("t3_req_pending");
      drv(); redirect = 1'b1; redirect_pc = 32'h0000_0103;
      drv(); redirect = 1'b0; ackDelay = 0;
      @(negedge clk);
      chkB("t3_drain_req", imem_req, 1'b1);
      chk("t3_drain_addr", imem_addr, 32'h14);
      waitAck("t3_drain_ack");
      @(negedge clk);
      chkB("t3_new_req", imem_req, 1'b1);
      chk("t3_new_addr", imem_addr, 32'h100);
      drv(); if_ready = 1'b0;
      waitValid(32'h100, "t3_valid_0x100");

      // 4: redirect and ready together in VALID at 0x20
      drv(); redirect = 1'b1; redirect_pc = 32'h20;
      drv(); redirect = 1'b0;
      waitValid(32'h20, "t4_valid_0x20");
      drv(); startQ.delete(); if_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h80;
      drv(); redirect = 1'b0;
      waitValid(32'h80, "t4_valid_0x80");
      chk("t4_first_fetch", (startQ.size() > 0) ? startQ[0] : 32'hFFFF_FFFF, 32'h80);
      cnt24 = 0;
      foreach (startQ[j]) if (startQ[j] == 32'h24) cnt24++;
      chk("t4_no_fetch_0x24", 32'(cnt24), 32'd0);

      // 5: wrap at the top word, stall across the handshake
      drv(); if_ready = 1'b0;
      waitValidAny("t5_valid_any");
      drv(); redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      drv(); redirect = 1'b0;
      waitValid(32'hFFFF_FFFC, "t5_valid_top");
      chk("t5_pc_plus4_wrap", if_pc_plus4, 32'h0);
      drv(); stall = 1'b1;
      @(negedge clk);
      chkB("t5_stall_keeps_valid", if_valid, 1'b1);
      drv(); if_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chkB("t5_stalled_no_req", imem_req, 1'b0);
      end
      drv(); stall = 1'b0;
      waitReq("t5_req_after_stall");
      chk("t5_wrap_addr", imem_addr, 32'h0);

      // async reset pulse while a request is outstanding
      drv(); ackDelay = 1000;
      waitReqNoAck("t6_req_pending");
      @(posedge clk); #3; rst_n = 1'b0;
      #1; checkResetValues("t6_async");
      drv(); rst_n = 1'b1; ackDelay = 0;
      waitValid(RST_PC, "t6_restart");

      // syscall word at 0x40
      drv(); if_ready = 1'b0;
      waitValidAny("t7_valid_any");
      drv(); redirect = 1'b1; redirect_pc = 32'h40;
      drv(); redirect = 1'b0;
      waitValid(32'h40, "t7_valid_0x40");
      chk("t7_syscall_inst", if_inst, 32'h0000_000C);
      drv(); if_ready = 1'b1;
`ifdef FETCH_HALT_EN
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chkB("t7_halted", halted, 1'b1);
         chkB("t7_halt_no_req", imem_req, 1'b0);
      end
      drv(); redirect = 1'b1; redirect_pc = 32'h200;
      drv(); redirect = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chkB("t7_redirect_ignored", imem_req, 1'b0);
         chkB("t7_still_halted", halted, 1'b1);
      end
      @(posedge clk); #3; rst_n = 1'b0;
      #1; checkResetValues("t7_reset_exit");
      drv(); rst_n = 1'b1;
`else
      waitReq("t7_req_after_syscall");
      chk("t7_next_addr", imem_addr, 32'h44);
      chkB("t7_not_halted", halted, 1'b0);
      waitValid(32'h44, "t7_valid_0x44");
`endif
      repeat (3) @(negedge clk);
      chkB("accepted_some", accepted > 10, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule
